// File: rtl/lagarto_fpu_pkg.sv
// Shared FPU types, constants and IEEE-754 double classification helpers.
package lagarto_fpu_pkg;

   typedef enum logic [3:0] {
      FMADD, FMSUB, FNMSUB, FNMADD,
      ADD, SUB, MUL, DIV,
      SQRT, SGNJ, MINMAX, CMP,
      CLASSIFY, F2F, F2I, I2F
   } fp_operation_t;

   // Quiet NaN with sign 0 and only the quiet bit set.
   localparam logic [63:0] CANONICAL_QNAN_D = 64'h7FF8000000000000;

   // RISC-V rounding modes.
   localparam logic [2:0] RM_RNE = 3'b000;
   localparam logic [2:0] RM_RTZ = 3'b001;
   localparam logic [2:0] RM_RDN = 3'b010;
   localparam logic [2:0] RM_RUP = 3'b011;
   localparam logic [2:0] RM_RMM = 3'b100;

   // One entry of the add/sub special stage: pass-through payload plus resolved result.
   typedef struct packed {
      fp_operation_t op;
      logic [2:0]    rm;
      logic [63:0]   a;
      logic [63:0]   b;
      logic          special;
      logic [63:0]   result;
      logic [4:0]    fflags;
   } fp_addsub_stage_t;

   function automatic logic is_nan_d(input logic [63:0] x);
      return (x[62:52] == 11'h7FF) && (x[51:0] != 52'd0);
   endfunction

   function automatic logic is_inf_d(input logic [63:0] x);
      return (x[62:52] == 11'h7FF) && (x[51:0] == 52'd0);
   endfunction

   function automatic logic is_zero_d(input logic [63:0] x);
      return x[62:0] == 63'd0;
   endfunction

endpackage

// File: rtl/lagarto_fp_skid_buffer.sv
// Output register plus optional one-entry skid register with valid/ready handshake.
// With SKID_EN=1 ready_o comes straight from a flop; with SKID_EN=0 it is combinational.
module lagarto_fp_skid_buffer #(
   parameter int DATA_W  = 8,
   parameter bit SKID_EN = 1'b1
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              kill_i,
   input  logic              valid_i,
   output logic              ready_o,
   input  logic [DATA_W-1:0] data_i,
   output logic              valid_o,
   input  logic              ready_i,
   output logic [DATA_W-1:0] data_o
);

   logic              vld_p1;
   logic [DATA_W-1:0] data_p1;

   assign valid_o = vld_p1;
   assign data_o  = data_p1;

   generate
      if (SKID_EN) begin : g_skid
         logic              skid_vld_p1;
         logic [DATA_W-1:0] skid_data_p1;
         logic              accept;
         logic              out_free;

         // Skid full is the only reason to refuse input, so ready is a pure flop output.
         assign ready_o  = ~skid_vld_p1;
         assign accept   = valid_i & ready_o;
         assign out_free = ~vld_p1 | ready_i;

         // Output register refills from skid first (preserves order), else from input; stalled accepts park in skid.
         always_ff @(posedge clk_i) begin
            if (rst_i) begin
               vld_p1       <= 1'b0;
               skid_vld_p1  <= 1'b0;
               data_p1      <= '0;
               skid_data_p1 <= '0;
            end else if (kill_i) begin
               vld_p1      <= 1'b0;
               skid_vld_p1 <= 1'b0;
            end else if (out_free) begin
               if (skid_vld_p1) begin
                  data_p1     <= skid_data_p1;
                  vld_p1      <= 1'b1;
                  skid_vld_p1 <= 1'b0;
               end else begin
                  vld_p1 <= accept;
                  if (accept) data_p1 <= data_i;
               end
            end else if (accept) begin
               skid_data_p1 <= data_i;
               skid_vld_p1  <= 1'b1;
            end
         end
      end else begin : g_noskid
         assign ready_o = ~vld_p1 | ready_i;

         // Plain pipeline register that advances whenever the consumer frees it.
         always_ff @(posedge clk_i) begin
            if (rst_i) begin
               vld_p1  <= 1'b0;
               data_p1 <= '0;
            end else if (kill_i) begin
               vld_p1 <= 1'b0;
            end else if (ready_o) begin
               vld_p1 <= valid_i;
               if (valid_i) data_p1 <= data_i;
            end
         end
      end
   endgenerate

endmodule

// File: rtl/lagarto_fp_adder_special_stage.sv
// FP add/sub special-case stage: resolves NaN, infinity and zero+zero operands for
// doubles, otherwise forwards the operands to the main adder. One registered stage.
module lagarto_fp_adder_special_stage
   import lagarto_fpu_pkg::*;
#(
   parameter bit SKID_EN = 1'b1
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          kill_i,
   input  logic          valid_i,
   output logic          ready_o,
   input  fp_operation_t fpu_op_i,
   input  logic [2:0]    rm_i,
   input  logic [63:0]   operand_a_i,
   input  logic [63:0]   operand_b_i,
   input  logic          invalid_operation_i,
   input  logic          is_snan_i,
   output logic          valid_o,
   input  logic          ready_i,
   output logic          special_o,
   output logic [63:0]   result_o,
   output logic [4:0]    fflags_o,
   output fp_operation_t fpu_op_o,
   output logic [2:0]    rm_o,
   output logic [63:0]   operand_a_o,
   output logic [63:0]   operand_b_o
);

   fp_addsub_stage_t stage_p0;
   fp_addsub_stage_t stage_p1;

   logic sb;
   logic a_nan, b_nan, a_inf, b_inf, both_zero;
   logic zero_sign;

   assign sb        = operand_b_i[63] ^ (fpu_op_i == SUB);
   assign a_nan     = is_nan_d(operand_a_i);
   assign b_nan     = is_nan_d(operand_b_i);
   assign a_inf     = is_inf_d(operand_a_i);
   assign b_inf     = is_inf_d(operand_b_i);
   assign both_zero = is_zero_d(operand_a_i) & is_zero_d(operand_b_i);
   // Exact zero sum of opposite-signed zeros is -0 only when rounding down.
   assign zero_sign = (operand_a_i[63] == sb) ? operand_a_i[63] : (rm_i == RM_RDN);

   // Classify the incoming operands in priority order and build the entry to capture.
   always_comb begin
      stage_p0.op      = fpu_op_i;
      stage_p0.rm      = rm_i;
      stage_p0.a       = operand_a_i;
      stage_p0.b       = operand_b_i;
      stage_p0.special = 1'b0;
      stage_p0.result  = 64'd0;
      stage_p0.fflags  = 5'd0;
      if (invalid_operation_i) begin
         stage_p0.special = 1'b1;
         stage_p0.result  = CANONICAL_QNAN_D;
         // Quiet-NaN propagation alone does not raise invalid.
         stage_p0.fflags  = {is_snan_i | (~a_nan & ~b_nan), 4'b0000};
      end else if (a_inf) begin
         stage_p0.special = 1'b1;
         stage_p0.result  = operand_a_i;
      end else if (b_inf) begin
         stage_p0.special = 1'b1;
         stage_p0.result  = {sb, operand_b_i[62:0]};
      end else if (both_zero) begin
         stage_p0.special = 1'b1;
         stage_p0.result  = {zero_sign, 63'd0};
      end
   end

   // ---- p0 -> p1 stage boundary ----
   lagarto_fp_skid_buffer #(
      .DATA_W  ($bits(fp_addsub_stage_t)),
      .SKID_EN (SKID_EN)
   ) u_skid (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .kill_i  (kill_i),
      .valid_i (valid_i),
      .ready_o (ready_o),
      .data_i  (stage_p0),
      .valid_o (valid_o),
      .ready_i (ready_i),
      .data_o  (stage_p1)
   );

   assign special_o   = stage_p1.special;
   assign result_o    = stage_p1.result;
   assign fflags_o    = stage_p1.fflags;
   assign fpu_op_o    = stage_p1.op;
   assign rm_o        = stage_p1.rm;
   assign operand_a_o = stage_p1.a;
   assign operand_b_o = stage_p1.b;

endmodule

// File: tb/tb_lagarto_fp_adder_special_stage.sv
// Bench for the FP add/sub special stage: directed special cases, backpressure,
// kill/reset flush, then a randomized stream checked against a queue model.
module tb_lagarto_fp_adder_special_stage;
   import lagarto_fpu_pkg::*;

   logic          clk = 1'b0;
   logic          rst_i, kill_i, valid_i, ready_o, ready_i, valid_o;
   fp_operation_t fpu_op_i, fpu_op_o;
   logic [2:0]    rm_i, rm_o;
   logic [63:0]   operand_a_i, operand_b_i, operand_a_o, operand_b_o, result_o;
   logic          invalid_operation_i, is_snan_i, special_o;
   logic [4:0]    fflags_o;

   int n_cmp = 0;
   int n_err = 0;

   fp_addsub_stage_t model_q[$];

   always #5 clk = ~clk;

   lagarto_fp_adder_special_stage #(.SKID_EN(1'b1)) dut (
      .clk_i               (clk),
      .rst_i               (rst_i),
      .kill_i              (kill_i),
      .valid_i             (valid_i),
      .ready_o             (ready_o),
      .fpu_op_i            (fpu_op_i),
      .rm_i                (rm_i),
      .operand_a_i         (operand_a_i),
      .operand_b_i         (operand_b_i),
      .invalid_operation_i (invalid_operation_i),
      .is_snan_i           (is_snan_i),
      .valid_o             (valid_o),
      .ready_i             (ready_i),
      .special_o           (special_o),
      .result_o            (result_o),
      .fflags_o            (fflags_o),
      .fpu_op_o            (fpu_op_o),
      .rm_o                (rm_o),
      .operand_a_o         (operand_a_o),
      .operand_b_o         (operand_b_o)
   );

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference: IEEE add/sub special-case resolution from the operand categories.
   function automatic fp_addsub_stage_t ref_entry(input fp_operation_t op, input logic [2:0] rm,
                                                  input logic [63:0] a, input logic [63:0] b,
                                                  input logic inv, input logic sn);
      fp_addsub_stage_t e;
      bit a_is_nan, b_is_nan, a_is_inf, b_is_inf, a_is_zero, b_is_zero, sign_b;
      a_is_nan  = (a[62:52] == 11'h7FF) && (a[51:0] != 0);
      b_is_nan  = (b[62:52] == 11'h7FF) && (b[51:0] != 0);
      a_is_inf  = (a[62:52] == 11'h7FF) && (a[51:0] == 0);
      b_is_inf  = (b[62:52] == 11'h7FF) && (b[51:0] == 0);
      a_is_zero = (a[62:0] == 0);
      b_is_zero = (b[62:0] == 0);
      sign_b    = (op == SUB) ? !b[63] : b[63];
      e = '{op: op, rm: rm, a: a, b: b, special: 1'b0, result: 64'd0, fflags: 5'd0};
      if (inv) begin
         e.special = 1'b1;
         e.result  = 64'h7FF8000000000000;
         e.fflags  = (sn || (!a_is_nan && !b_is_nan)) ? 5'b10000 : 5'b00000;
      end else if (a_is_inf) begin
         e.special = 1'b1;
         e.result  = a;
      end else if (b_is_inf) begin
         e.special = 1'b1;
         e.result  = sign_b ? (b | 64'h8000000000000000) : (b & 64'h7FFFFFFFFFFFFFFF);
      end else if (a_is_zero && b_is_zero) begin
         e.special = 1'b1;
         if (a[63] == sign_b) e.result = a[63] ? 64'h8000000000000000 : 64'd0;
         else                 e.result = (rm == 3'b010) ? 64'h8000000000000000 : 64'd0;
      end
      return e;
   endfunction

   task automatic set_in(input fp_operation_t op, input logic [2:0] rm, input logic [63:0] a,
                         input logic [63:0] b, input logic inv, input logic sn);
      fpu_op_i = op; rm_i = rm; operand_a_i = a; operand_b_i = b;
      invalid_operation_i = inv; is_snan_i = sn;
   endtask

   // Present one entry with ready_i=1 and step to where it sits on the outputs.
   task automatic send_dir(input fp_operation_t op, input logic [2:0] rm, input logic [63:0] a,
                           input logic [63:0] b, input logic inv, input logic sn);
      set_in(op, rm, a, b, inv, sn);
      valid_i = 1'b1;
      @(posedge clk); #1;
      valid_i = 1'b0;
      check_val("dir_valid", valid_o, 1'b1);
   endtask

   // Load output and skid with two entries while stalled.
   task automatic fill_two();
      ready_i = 1'b0;
      set_in(ADD, RM_RDN, 64'h3FF0000000000000, 64'h7FF0000000000000, 1'b0, 1'b0);
      valid_i = 1'b1;
      @(posedge clk); #1;
      set_in(ADD, RM_RDN, 64'h4000000000000000, 64'h7FF0000000000000, 1'b0, 1'b0);
      @(posedge clk); #1;
      check_val("fill_ready_low", ready_o, 1'b0);
      check_val("fill_valid", valid_o, 1'b1);
   endtask

   function automatic logic [63:0] rand_operand();
      logic [63:0] r;
      logic        s;
      r = {$urandom, $urandom};
      s = r[63];
      case ($urandom_range(0, 6))
         0:       return {s, 63'd0};
         1:       return {s, 11'h7FF, 52'd0};
         2:       return {s, 11'h7FF, 1'b1, r[50:0]};
         3:       return {s, 11'h7FF, 1'b0, r[50:1], 1'b1};
         default: return {s, 11'($urandom_range(1, 2046)), r[51:0]};
      endcase
   endfunction

   task automatic rand_inputs();
      logic [63:0] a, b;
      fp_operation_t op;
      bit an, bn, asn, bsn, ainf, binf, sbe;
      a  = rand_operand();
      b  = rand_operand();
      op = ($urandom_range(0, 1) == 1) ? SUB : ADD;
      an   = (a[62:52] == 11'h7FF) && (a[51:0] != 0);
      bn   = (b[62:52] == 11'h7FF) && (b[51:0] != 0);
      asn  = an && !a[51];
      bsn  = bn && !b[51];
      ainf = (a[62:52] == 11'h7FF) && (a[51:0] == 0);
      binf = (b[62:52] == 11'h7FF) && (b[51:0] == 0);
      sbe  = b[63] ^ (op == SUB);
      set_in(op, 3'($urandom_range(0, 4)), a, b, an || bn || (ainf && binf && (a[63] != sbe)), asn || bsn);
   endtask

   fp_addsub_stage_t exp_e;

   initial begin
      rst_i = 1'b1; kill_i = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
      set_in(ADD, RM_RNE, 64'd0, 64'd0, 1'b0, 1'b0);
      repeat (2) @(posedge clk);
      #1 rst_i = 1'b0;
      check_val("rst_valid", valid_o, 1'b0);
      check_val("rst_ready", ready_o, 1'b1);
      check_val("rst_result", result_o, 64'd0);
      check_val("rst_opa", operand_a_o, 64'd0);
      check_val("rst_fflags", fflags_o, 5'd0);

      // +inf - +inf via ADD of opposite infinities
      send_dir(ADD, RM_RNE, 64'h7FF0000000000000, 64'hFFF0000000000000, 1'b1, 1'b0);
      check_val("infinf_special", special_o, 1'b1);
      check_val("infinf_result", result_o, 64'h7FF8000000000000);
      check_val("infinf_flags", fflags_o, 5'b10000);
      // quiet NaN: no NV
      send_dir(ADD, RM_RNE, 64'h7FF8000000000001, 64'h3FF0000000000000, 1'b1, 1'b0);
      check_val("qnan_result", result_o, 64'h7FF8000000000000);
      check_val("qnan_flags", fflags_o, 5'b00000);
      // signalling NaN: NV
      send_dir(ADD, RM_RNE, 64'h7FF0000000000001, 64'h3FF0000000000000, 1'b1, 1'b1);
      check_val("snan_flags", fflags_o, 5'b10000);
      // +0 - +0
      send_dir(SUB, RM_RDN, 64'd0, 64'd0, 1'b0, 1'b0);
      check_val("zero_rdn_result", result_o, 64'h8000000000000000);
      check_val("zero_rdn_special", special_o, 1'b1);
      send_dir(SUB, RM_RNE, 64'd0, 64'd0, 1'b0, 1'b0);
      check_val("zero_rne_result", result_o, 64'h0000000000000000);
      // 1.0 - +inf
      send_dir(SUB, RM_RNE, 64'h3FF0000000000000, 64'h7FF0000000000000, 1'b0, 1'b0);
      check_val("binf_result", result_o, 64'hFFF0000000000000);
      check_val("binf_flags", fflags_o, 5'b00000);
      // 1.0 + 2.0 passes through
      send_dir(ADD, RM_RUP, 64'h3FF0000000000000, 64'h4000000000000000, 1'b0, 1'b0);
      check_val("norm_special", special_o, 1'b0);
      check_val("norm_result", result_o, 64'd0);
      check_val("norm_opa", operand_a_o, 64'h3FF0000000000000);
      check_val("norm_opb", operand_b_o, 64'h4000000000000000);
      check_val("norm_rm", rm_o, RM_RUP);
      check_val("norm_op", fpu_op_o, ADD);
      @(posedge clk); #1;
      check_val("idle_valid", valid_o, 1'b0);

      // Backpressure: three back-to-back entries with consumer stalled
      ready_i = 1'b0;
      set_in(ADD, RM_RNE, 64'h3FF0000000000000, 64'h3FF0000000000000, 1'b0, 1'b0);
      valid_i = 1'b1;
      @(posedge clk); #1;
      check_val("bp_ready1", ready_o, 1'b1);
      set_in(ADD, RM_RNE, 64'h4000000000000000, 64'h3FF0000000000000, 1'b0, 1'b0);
      @(posedge clk); #1;
      check_val("bp_ready2", ready_o, 1'b0);
      check_val("bp_out_e1", operand_a_o, 64'h3FF0000000000000);
      set_in(ADD, RM_RNE, 64'h4008000000000000, 64'h3FF0000000000000, 1'b0, 1'b0);
      @(posedge clk); #1;
      check_val("bp_hold_e1", operand_a_o, 64'h3FF0000000000000);
      check_val("bp_hold_ready", ready_o, 1'b0);
      ready_i = 1'b1;
      @(posedge clk); #1;
      check_val("bp_drain_e2", operand_a_o, 64'h4000000000000000);
      check_val("bp_drain_v2", valid_o, 1'b1);
      check_val("bp_ready_back", ready_o, 1'b1);
      @(posedge clk); #1;
      valid_i = 1'b0;
      check_val("bp_drain_e3", operand_a_o, 64'h4008000000000000);
      check_val("bp_drain_v3", valid_o, 1'b1);
      @(posedge clk); #1;
      check_val("bp_empty", valid_o, 1'b0);

      // Kill with output and skid full, input presented in the same cycle
      fill_two();
      kill_i = 1'b1;
      @(posedge clk); #1;
      kill_i = 1'b0; valid_i = 1'b0;
      check_val("kill_valid", valid_o, 1'b0);
      check_val("kill_ready", ready_o, 1'b1);
      ready_i = 1'b1;
      @(posedge clk); #1;
      check_val("kill_nothing", valid_o, 1'b0);

      // Same with reset
      fill_two();
      rst_i = 1'b1;
      @(posedge clk); #1;
      rst_i = 1'b0; valid_i = 1'b0;
      check_val("rst2_valid", valid_o, 1'b0);
      check_val("rst2_ready", ready_o, 1'b1);
      check_val("rst2_result", result_o, 64'd0);
      check_val("rst2_special", special_o, 1'b0);
      check_val("rst2_opa", operand_a_o, 64'd0);
      check_val("rst2_opb", operand_b_o, 64'd0);
      check_val("rst2_rm", rm_o, 3'd0);
      ready_i = 1'b1;
      @(posedge clk); #1;
      check_val("rst2_nothing", valid_o, 1'b0);

      // Randomized stream with random backpressure and occasional kill
      for (int cyc = 0; cyc < 3000; cyc++) begin
         check_val("rnd_valid", valid_o, model_q.size() > 0);
         check_val("rnd_ready", ready_o, model_q.size() < 2);
         if (model_q.size() > 0) begin
            check_val("rnd_special", special_o, model_q[0].special);
            check_val("rnd_result", result_o, model_q[0].result);
            check_val("rnd_fflags", fflags_o, model_q[0].fflags);
            check_val("rnd_opa", operand_a_o, model_q[0].a);
            check_val("rnd_opb", operand_b_o, model_q[0].b);
            check_val("rnd_op", fpu_op_o, model_q[0].op);
            check_val("rnd_rm", rm_o, model_q[0].rm);
         end
         rand_inputs();
         valid_i = ($urandom_range(0, 3) != 0);
         ready_i = ($urandom_range(0, 2) != 0);
         kill_i  = ($urandom_range(0, 99) == 0);
         exp_e   = ref_entry(fpu_op_i, rm_i, operand_a_i, operand_b_i, invalid_operation_i, is_snan_i);
         if (kill_i) begin
            model_q.delete();
         end else begin
            bit can_take;
            can_take = model_q.size() < 2;
            if (model_q.size() > 0 && ready_i) void'(model_q.pop_front());
            if (valid_i && can_take) model_q.push_back(exp_e);
         end
         @(posedge clk); #1;
      end
      valid_i = 1'b0; kill_i = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
